scene_scheduler: RTL and testbench
==================================

# scene_scheduler

Frame-level sequencer that drives a 64×64 pixel painter (`painter24`-style: coordinates in, registered RGB out after a fixed latency) and writes the painted pixels into the LED panel framebuffer. Each frame it scans all 4096 coordinates in raster order, holds `frame` and `scene` stable for the whole scan, and emits write strobes aligned to the painter latency. It also selects which of `SCENES` painters is active, advancing automatically every `SCENE_FRAMES` frames or on a button pulse, always at a frame boundary. It sits between the LED driver's frame timing and the painter bank / framebuffer write port.

## Interface
- `FRAME_BITS`, 12, width of the frame counter presented to painters
- `SCENES`, 4, number of painters selectable; scene index width is 2
- `SCENE_FRAMES`, 1024, frames per scene before auto-advance (≥1)
- `PAINT_LATENCY`, 1, painter input-to-RGB latency in cycles (1..4)

- `clk`  in  1  system clock
- `resetn`  in  1  reset, synchronous, active-low
- `frame_start`  in  1  one-cycle pulse from LED driver: begin painting next frame
- `next_btn`  in  1  one-cycle debounced pulse: request scene advance
- `fb_ready`  in  1  framebuffer may accept new coordinates this cycle
- `frame`  out  FRAME_BITS  frame number to painters, stable during a scan
- `scene`  out  2  active painter select, stable during a scan
- `x`, `y`  out  6 each  painter coordinates
- `pix_we`  out  1  write strobe, painter RGB valid this cycle
- `pix_x`, `pix_y`  out  6 each  framebuffer address for `pix_we`
- `busy`  out  1  high in SCAN, DRAIN, DONE
- `frame_done`  out  1  one-cycle pulse in DONE
- `drop_count`  out  8  saturating count of ignored `frame_start` pulses

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: `frame_start` → SCAN; coordinate counter = (0,0).
- SCAN: each cycle with `fb_ready`=1 issue current (x,y) and advance, x fastest (x 63→0 increments y). `fb_ready`=0: hold x,y, no issue. Issue of (63,63) → DRAIN.
- DRAIN: exactly `PAINT_LATENCY` cycles regardless of `fb_ready`, then DONE.
- DONE: one cycle; `frame_done`=1; `frame` += 1 (wraps at 2^FRAME_BITS); scene update applied; → IDLE.
- Write pipeline: a shift register of depth `PAINT_LATENCY` carries {issue, x, y}; `pix_we`/`pix_x`/`pix_y` are its output. Writes for coordinates already issued complete even after `fb_ready` drops; the framebuffer must accept them.
- Scene update in DONE: step if `next_pending` or `frames_in_scene` == SCENE_FRAMES−1. Step: `scene` = (scene+1) mod SCENES, `frames_in_scene`=0, `next_pending`=0. Otherwise `frames_in_scene` += 1. Button and auto-advance in the same frame produce one step only.
- `next_btn` in any state sets `next_pending`; multiple pulses in one frame → one step. `next_btn` in the DONE cycle itself is kept for the following frame.
- `frame_start` outside IDLE (including DONE) is ignored; `drop_count` += 1, saturating at 255.
- `x`,`y` outside SCAN hold last value (0,0 after reset); painters' outputs outside `pix_we` are don't-care.

## Timing
- Reset (`resetn`=0 at a clock edge): state IDLE; `frame`=0, `scene`=0, `x`=`y`=0, `pix_we`=0, `pix_x`=`pix_y`=0, `busy`=0, `frame_done`=0, `drop_count`=0, `frames_in_scene`=0, `next_pending`=0, write pipeline cleared. Reset mid-scan aborts the frame; no further `pix_we`.
- `frame_start` at cycle t (IDLE) → `busy`=1 and first issue (0,0) at t+1.
- Issue at cycle c → `pix_we` with matching `pix_x`/`pix_y` at c+PAINT_LATENCY.
- With `fb_ready` held high: 4096 SCAN + PAINT_LATENCY DRAIN + 1 DONE cycles; `frame_start` accepted again the cycle after DONE.
- New `frame`/`scene` visible the cycle after DONE.

## Test plan
- Reset then `frame_start`, `fb_ready`=1, PAINT_LATENCY=1 → 4096 `pix_we` in raster order, first at t+2, `frame_done` at t+4098, `frame` 0→1, `busy` low at t+4099.
- `fb_ready` toggled 0/1 pseudo-randomly → each coordinate written exactly once, in order, no gaps or duplicates; in-flight writes complete during `fb_ready`=0.
- SCENE_FRAMES=3, run 7 frames → `scene` sequence 0,0,0,1,1,1,2; no `next_btn`.
- Three `next_btn` pulses mid-frame plus auto-advance boundary in the same frame → `scene` advances by 1, `frames_in_scene`=0.
- `frame_start` pulsed every 1000 cycles for 300 pulses → `drop_count` saturates at 255; frames still complete normally.
- `resetn` low at the 2000th issue → all outputs at reset values next cycle, no `pix_we` afterwards; next `frame_start` restarts at (0,0) with `frame`=0.

Source files
------------

// File: rtl/scene_scheduler.sv
// -----------------------------------------------------------------------------
// scene_scheduler
//
// Frame-level sequencer between the LED driver's frame timing and a bank of
// 64x64 painters plus the panel framebuffer write port. On each accepted
// frame_start it scans all 4096 coordinates in raster order (x fastest),
// keeps frame/scene stable for the scan, and emits framebuffer write strobes
// delayed by the painter latency. At every frame boundary the active scene
// advances, either automatically after SCENE_FRAMES frames or on request
// from next_btn.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   frame_start          pulse from LED driver: paint next frame (IDLE only)
//   next_btn             debounced pulse: request scene advance
//   fb_ready             framebuffer accepts a new coordinate this cycle
//   frame                frame number to painters
//   scene                active painter select
//   x, y                 painter coordinates
//   pix_we, pix_x, pix_y framebuffer write strobe and address
//   busy                 high in SCAN, DRAIN, DONE
//   frame_done           one-cycle pulse in DONE
//   drop_count           saturating count of ignored frame_start pulses
// -----------------------------------------------------------------------------
module scene_scheduler #(
    parameter int FRAME_BITS    = 12,
    parameter int SCENES        = 4,
    parameter int SCENE_FRAMES  = 1024,
    parameter int PAINT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  frame_start,
    input  logic                  next_btn,
    input  logic                  fb_ready,
    output logic [FRAME_BITS-1:0] frame,
    output logic [1:0]            scene,
    output logic [5:0]            x,
    output logic [5:0]            y,
    output logic                  pix_we,
    output logic [5:0]            pix_x,
    output logic [5:0]            pix_y,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            drop_count
);

    localparam int FIS_W = (SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1;
    localparam logic [FIS_W-1:0] FIS_LAST   = FIS_W'(SCENE_FRAMES - 1);
    localparam logic [1:0]       SCENE_LAST = 2'(SCENES - 1);
    localparam logic [2:0]       DRAIN_LAST = 3'(PAINT_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            x_q, x_d;
    logic [5:0]            y_q, y_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [1:0]            scene_q, scene_d;
    logic [FIS_W-1:0]      fis_q, fis_d;
    logic                  pend_q, pend_d;
    logic [7:0]            drop_q, drop_d;
    logic [2:0]            drain_q, drain_d;
    logic                  issue;
    logic                  step;

    // Write pipeline entries: {issue, x, y}
    logic [12:0] pipe_q [PAINT_LATENCY];
    logic [12:0] pipe_d [PAINT_LATENCY];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        scene_d = scene_q;
        fis_d   = fis_q;
        drain_d = drain_q;
        drop_d  = drop_q;
        issue   = 1'b0;
        step    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_SCAN;
                    x_d     = 6'd0;
                    y_d     = 6'd0;
                end
            end
            S_SCAN: begin
                if (fb_ready) begin
                    issue = 1'b1;
                    x_d   = x_q + 6'd1;
                    if (x_q == 6'd63) begin
                        y_d = y_q + 6'd1;
                    end
                    if (x_q == 6'd63 && y_q == 6'd63) begin
                        state_d = S_DRAIN;
                        drain_d = 3'd0;
                    end
                end
            end
            S_DRAIN: begin
                // Fixed length so the last issued coordinate reaches pix_we
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                frame_d = frame_q + 1'b1;
                // Button and auto-advance collapse into a single step
                step    = pend_q || (fis_q == FIS_LAST);
                if (step) begin
                    scene_d = (scene_q == SCENE_LAST) ? 2'd0 : scene_q + 2'd1;
                    fis_d   = '0;
                end else begin
                    fis_d   = fis_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A press arriving in the DONE cycle survives into the next frame
        pend_d = (pend_q && !step) || next_btn;

        if (frame_start && state_q != S_IDLE && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < PAINT_LATENCY; i++) begin
            pipe_d[i] = (i == 0) ? {issue, x_q, y_q} : pipe_q[(i == 0) ? 0 : i - 1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x_q     <= 6'd0;
            y_q     <= 6'd0;
            frame_q <= '0;
            scene_q <= 2'd0;
            fis_q   <= '0;
            pend_q  <= 1'b0;
            drop_q  <= 8'd0;
            drain_q <= 3'd0;
            for (int i = 0; i < PAINT_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            scene_q <= scene_d;
            fis_q   <= fis_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            drain_q <= drain_d;
            for (int i = 0; i < PAINT_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign frame      = frame_q;
    assign scene      = scene_q;
    assign x          = x_q;
    assign y          = y_q;
    assign pix_we     = pipe_q[PAINT_LATENCY-1][12];
    assign pix_x      = pipe_q[PAINT_LATENCY-1][11:6];
    assign pix_y      = pipe_q[PAINT_LATENCY-1][5:0];
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_scene_scheduler.sv
// -----------------------------------------------------------------------------
// tb_scene_scheduler
//
// Bench for scene_scheduler (SCENE_FRAMES=3, PAINT_LATENCY=1). Each frame the
// full raster of expected write addresses is queued; every pix_we pops and
// compares one entry. A table of frame records drives ready pattern and
// button activity and gives the expected frame/scene after each frame.
// Hand-written sequences cover reset values, first-frame timing, drop_count
// saturation and reset in the middle of a scan.
// -----------------------------------------------------------------------------
module tb_scene_scheduler;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_start;
    logic        next_btn;
    logic        fb_ready;
    logic [11:0] frame;
    logic [1:0]  scene;
    logic [5:0]  x, y;
    logic        pix_we;
    logic [5:0]  pix_x, pix_y;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_count;

    scene_scheduler #(
        .FRAME_BITS   (12),
        .SCENES       (4),
        .SCENE_FRAMES (3),
        .PAINT_LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_start(frame_start),
        .next_btn   (next_btn),
        .fb_ready   (fb_ready),
        .frame      (frame),
        .scene      (scene),
        .x          (x),
        .y          (y),
        .pix_we     (pix_we),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;       // 0: fb_ready high, 1: pseudo-random
        int btn;        // next_btn pulses during the scan
        bit bdone;      // pulse next_btn in the DONE cycle
        int exp_scene;  // scene after the frame
        int exp_frame;  // frame after the frame
    } vec_t;

    vec_t        vecs[14];
    int          chk = 0;
    int          err = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          first_we_cyc = 0;
    int          t_start = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: sample outputs at the falling edge, run the
    // scoreboard, then return 1 time unit after the next rising edge.
    task automatic tick();
        logic [11:0] e;
        @(negedge clk);
        if (pix_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk++;
                err++;
                $display("FAIL unexpected_write: got pix_we=%b at (%0d,%0d) expected no write (cycle %0d)",
                         pix_we, pix_x, pix_y, cyc);
            end else begin
                e = exp_q.pop_front();
                wr_count++;
                if (wr_count == 1) first_we_cyc = cyc;
                check("write_addr", 32'({pix_x, pix_y}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_frame();
        for (int yy = 0; yy < 64; yy++) begin
            for (int xx = 0; xx < 64; xx++) begin
                exp_q.push_back(12'(xx * 64 + yy));
            end
        end
    endtask

    task automatic run_frame(input int mode, input int btn_n, input bit btn_done, input int fs_n,
                             input int ef, input int es, output int done_off);
        push_frame();
        wr_count    = 0;
        t_start     = cyc;
        done_off    = -1;
        fb_ready    = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 1; k < 20000; k++) begin
            fb_ready    = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            next_btn    = (k == 100 && btn_n > 0) || (k == 200 && btn_n > 1) || (k == 300 && btn_n > 2);
            frame_start = (k >= 10 && k < 10 + fs_n);
            if (k == 1) begin
                check("busy_at_start", 32'(busy), 1);
                check("first_coord", 32'({x, y}), 0);
                check("frame_at_start", 32'(frame), 32'(ef));
            end
            if (frame_done === 1'b1) begin
                done_off = k;
                check("frame_stable", 32'(frame), 32'(ef));
                check("scene_stable", 32'(scene), 32'(es));
                next_btn    = btn_done;
                frame_start = 1'b0;
                tick();
                break;
            end
            tick();
        end
        next_btn    = 1'b0;
        frame_start = 1'b0;
        fb_ready    = 1'b1;
        if (done_off < 0) begin
            chk++;
            err++;
            $display("FAIL frame_timeout: got no frame_done expected one within 20000 cycles");
        end
        check("busy_after_done", 32'(busy), 0);
        check("writes_per_frame", 32'(wr_count), 4096);
        exp_q.delete();
    endtask

    initial begin
        int d;
        int ef;
        int es;

        //          mode btn bdone scene frame
        vecs[0]  = '{0, 0, 0, 0, 2};
        vecs[1]  = '{1, 0, 0, 1, 3};
        vecs[2]  = '{0, 0, 0, 1, 4};
        vecs[3]  = '{0, 0, 0, 1, 5};
        vecs[4]  = '{0, 0, 0, 2, 6};
        vecs[5]  = '{0, 0, 0, 2, 7};
        vecs[6]  = '{1, 0, 0, 2, 8};
        vecs[7]  = '{0, 3, 0, 3, 9};
        vecs[8]  = '{0, 0, 0, 3, 10};
        vecs[9]  = '{0, 0, 0, 3, 11};
        vecs[10] = '{0, 0, 0, 0, 12};
        vecs[11] = '{0, 1, 0, 1, 13};
        vecs[12] = '{0, 0, 1, 1, 14};
        vecs[13] = '{0, 0, 0, 2, 15};

        resetn      = 1'b0;
        frame_start = 1'b0;
        next_btn    = 1'b0;
        fb_ready    = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        check("rst_frame", 32'(frame), 0);
        check("rst_scene", 32'(scene), 0);
        check("rst_xy", 32'({x, y}), 0);
        check("rst_pix_we", 32'(pix_we), 0);
        check("rst_pix_xy", 32'({pix_x, pix_y}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_drop", 32'(drop_count), 0);
        resetn = 1'b1;
        tick();

        // First frame: latency and length with fb_ready held high
        run_frame(0, 0, 1'b0, 0, 0, 0, d);
        check("done_latency", 32'(d), 32'(4096 + LAT + 1));
        check("first_write_latency", 32'(first_we_cyc - t_start), 32'(1 + LAT));
        check("frame_after_0", 32'(frame), 1);
        check("scene_after_0", 32'(scene), 0);

        ef = 1;
        es = 0;
        for (int i = 0; i < 14; i++) begin
            run_frame(vecs[i].mode, vecs[i].btn, vecs[i].bdone, 0, ef, es, d);
            check("vec_frame", 32'(frame), 32'(vecs[i].exp_frame));
            check("vec_scene", 32'(scene), 32'(vecs[i].exp_scene));
            ef = vecs[i].exp_frame;
            es = vecs[i].exp_scene;
            $display("frame %0d done: frame=%0d scene=%0d", i + 1, frame, scene);
        end

        // Ignored frame_start pulses during a scan saturate drop_count
        check("drop_before", 32'(drop_count), 0);
        run_frame(0, 0, 1'b0, 300, ef, es, d);
        check("drop_saturated", 32'(drop_count), 255);
        check("drop_frame", 32'(frame), 32'(ef + 1));
        check("drop_scene", 32'(scene), 2);
        $display("drop frame done: drop_count=%0d", drop_count);

        // Reset asserted during the cycle of the 2000th issue
        push_frame();
        wr_count    = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (1999) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst_writes", 32'(wr_count), 1999);
        check("midrst_frame", 32'(frame), 0);
        check("midrst_scene", 32'(scene), 0);
        check("midrst_xy", 32'({x, y}), 0);
        check("midrst_pix_we", 32'(pix_we), 0);
        check("midrst_pix_xy", 32'({pix_x, pix_y}), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_frame_done", 32'(frame_done), 0);
        check("midrst_drop", 32'(drop_count), 0);
        exp_q.delete();
        repeat (10) tick();
        $display("mid-scan reset done: writes before reset=%0d", wr_count);

        run_frame(0, 0, 1'b0, 0, 0, 0, d);
        check("post_rst_frame", 32'(frame), 1);
        check("post_rst_scene", 32'(scene), 0);
        $display("post-reset frame done: frame=%0d scene=%0d", frame, scene);

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
